mux41_rr_sched: RTL

MUX41_RR_SCHED -- requirements
Module: mux41_rr_sched

---
 rtl/mux_sched_pkg.sv | 36 +++
 rtl/mux41_w.sv | 27 ++
 rtl/mux41_rr_sched.sv | 118 +++++++++++
 3 files changed

// File: rtl/mux_sched_pkg.sv
// Shared types and helpers for the round-robin 4:1 output scheduler.
package mux_sched_pkg;

  localparam int NREQ = 4;

  // Scheduler FSM states: no word held / word held on the output.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Requester index, also the mux select pair.
  typedef logic [1:0] sel_t;

  // One-hot decode of a requester index.
  function automatic logic [NREQ-1:0] onehot(input sel_t s);
    return NREQ'(1) << s;
  endfunction

  // Round-robin pick: rotate the mask so 'base' sits at bit 0, take the
  // lowest set bit, then rotate the offset back. Result is meaningless
  // when mask is zero; callers qualify it with |mask.
  function automatic sel_t rr_pick(input logic [NREQ-1:0] mask, input sel_t base);
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    sel_t              off;
    dbl = {mask, mask};
    rot = dbl[base +: NREQ];
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = sel_t'(i);
    end
    return sel_t'(base + off);
  endfunction

endpackage

// File: rtl/mux41_w.sv
// W-bit combinational 4:1 data mux driven by the arbiter's next-grant index.
module mux41_w
  import mux_sched_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] din0,
  input  logic [W-1:0] din1,
  input  logic [W-1:0] din2,
  input  logic [W-1:0] din3,
  input  sel_t         sel,
  output logic [W-1:0] dout
);

  // Pure select, no storage.
  always_comb begin
    dout = din0;
    unique case (sel)
      2'd0: dout = din0;
      2'd1: dout = din1;
      2'd2: dout = din2;
      2'd3: dout = din3;
      default: dout = din0;
    endcase
  end

endmodule

// File: rtl/mux41_rr_sched.sv
// Round-robin scheduler feeding a registered 4:1 mux onto a valid/ready output.
//
// Handshake: out_data/out_sel are offered while out_valid is high and stay
// stable until a cycle with out_valid && out_ready; in that cycle the word is
// consumed, ack[out_sel] pulses combinationally and a new word may be captured
// in the same cycle so one word per cycle can be sustained. The requester being
// acknowledged is masked out of that cycle's arbitration.
module mux41_rr_sched
  import mux_sched_pkg::*;
#(
  parameter int W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [W-1:0]    din0,
  input  logic [W-1:0]    din1,
  input  logic [W-1:0]    din2,
  input  logic [W-1:0]    din3,
  output logic [NREQ-1:0] ack,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output sel_t            out_sel,
  output logic            busy
);

  state_e          state_q, state_d;
  sel_t            ptr_q, ptr_d;
  logic [W-1:0]    out_data_q, out_data_d;
  sel_t            out_sel_q, out_sel_d;

  logic            hs;
  logic [NREQ-1:0] arb_mask;
  sel_t            arb_base;
  sel_t            grant;
  logic            grant_any;
  logic [W-1:0]    mux_data;

  assign hs = (state_q == HOLD) && out_ready;

  // Select who competes and from which priority origin this cycle.
  always_comb begin
    arb_mask = '0;
    arb_base = ptr_q;
    if (state_q == IDLE) begin
      arb_mask = req;
    end else if (hs) begin
      arb_mask = req & ~onehot(out_sel_q);
      arb_base = out_sel_q + 2'd1;
    end
  end

  assign grant     = rr_pick(arb_mask, arb_base);
  assign grant_any = |arb_mask;

  mux41_w #(.W(W)) u_mux (
    .din0 (din0),
    .din1 (din1),
    .din2 (din2),
    .din3 (din3),
    .sel  (grant),
    .dout (mux_data)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: capture on any grant, release when a handshake finds no one.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_any) state_d = HOLD;
      HOLD:    if (hs) state_d = grant_any ? HOLD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: ack only in a handshake cycle, valid/busy mirror HOLD.
  always_comb begin
    ack       = '0;
    out_valid = (state_q == HOLD);
    busy      = (state_q == HOLD);
    if (hs) ack = onehot(out_sel_q);
  end

  // Datapath next values: pointer advances past the consumed owner, capture on grant.
  always_comb begin
    ptr_d      = ptr_q;
    out_data_d = out_data_q;
    out_sel_d  = out_sel_q;
    if (hs) ptr_d = out_sel_q + 2'd1;
    if (grant_any) begin
      out_data_d = mux_data;
      out_sel_d  = grant;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      out_data_q <= '0;
      out_sel_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      out_data_q <= out_data_d;
      out_sel_q  <= out_sel_d;
    end
  end

  assign out_data = out_data_q;
  assign out_sel  = out_sel_q;

endmodule
